// File: rtl/robo_escalonador.sv
// Actuator command scheduler: fixed-priority arbitration between the safety and
// navigation requesters, with a timed actuator pulse per command and a bumper abort.
module robo_escalonador #(
   parameter int PASSO_FRENTE  = 4,
   parameter int PASSO_GIRO    = 6,
   parameter int PASSO_REMOVER = 8,
   parameter int CNT_W         = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_nav,
   input  logic [1:0] cmd_nav,
   output logic       ack_nav,
   input  logic       req_seg,
   input  logic [1:0] cmd_seg,
   output logic       ack_seg,
   input  logic       B,
   output logic       motor_frente,
   output logic       motor_giro,
   output logic       garra,
   output logic       ocupado,
   output logic       concluido,
   output logic       abortado
);

   typedef enum logic [1:0] {OCIOSO, EXECUTA, PAUSA} estado_t;

   localparam logic [1:0] CMD_NADA    = 2'b00;
   localparam logic [1:0] CMD_FRENTE  = 2'b01;
   localparam logic [1:0] CMD_GIRO    = 2'b10;
   localparam logic [1:0] CMD_REMOVER = 2'b11;

   // Counter is preloaded with N-1 so the actuator is high for exactly N cycles.
   function automatic logic [CNT_W-1:0] duracao(input logic [1:0] c);
      case (c)
         CMD_FRENTE:  duracao = CNT_W'(PASSO_FRENTE - 1);
         CMD_GIRO:    duracao = CNT_W'(PASSO_GIRO - 1);
         CMD_REMOVER: duracao = CNT_W'(PASSO_REMOVER - 1);
         default:     duracao = '0;
      endcase
   endfunction

   // Actuator vector ordered {frente, giro, garra}; one-hot by construction.
   function automatic logic [2:0] atuadores(input logic [1:0] c);
      case (c)
         CMD_FRENTE:  atuadores = 3'b100;
         CMD_GIRO:    atuadores = 3'b010;
         CMD_REMOVER: atuadores = 3'b001;
         default:     atuadores = 3'b000;
      endcase
   endfunction

   estado_t          estado, estado_n;
   logic [1:0]       cmd_ativo, cmd_ativo_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       atu_n;
   logic             ack_nav_n, ack_seg_n, concluido_n, abortado_n;
   logic             valido_nav, valido_seg;

   assign valido_nav = req_nav && (cmd_nav != CMD_NADA);
   assign valido_seg = req_seg && (cmd_seg != CMD_NADA);

   always_comb begin
      estado_n    = estado;
      cmd_ativo_n = cmd_ativo;
      cnt_n       = cnt;
      atu_n       = 3'b000;
      ack_nav_n   = 1'b0;
      ack_seg_n   = 1'b0;
      concluido_n = 1'b0;
      abortado_n  = 1'b0;
      case (estado)
         OCIOSO: begin
            if (valido_seg) begin
               cmd_ativo_n = cmd_seg;
               cnt_n       = duracao(cmd_seg);
               atu_n       = atuadores(cmd_seg);
               ack_seg_n   = 1'b1;
               estado_n    = EXECUTA;
            end else if (valido_nav) begin
               cmd_ativo_n = cmd_nav;
               cnt_n       = duracao(cmd_nav);
               atu_n       = atuadores(cmd_nav);
               ack_nav_n   = 1'b1;
               estado_n    = EXECUTA;
            end
         end
         EXECUTA: begin
            // Bumper takes precedence even on the last cycle of an advance.
            if (cmd_ativo == CMD_FRENTE && B) begin
               concluido_n = 1'b1;
               abortado_n  = 1'b1;
               estado_n    = PAUSA;
            end else if (cnt == '0) begin
               concluido_n = 1'b1;
               estado_n    = PAUSA;
            end else begin
               cnt_n = cnt - 1'b1;
               atu_n = atuadores(cmd_ativo);
            end
         end
         PAUSA: begin
            estado_n = OCIOSO;
         end
         default: begin
            estado_n = OCIOSO;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado       <= OCIOSO;
         cmd_ativo    <= CMD_NADA;
         cnt          <= '0;
         motor_frente <= 1'b0;
         motor_giro   <= 1'b0;
         garra        <= 1'b0;
         ack_nav      <= 1'b0;
         ack_seg      <= 1'b0;
         ocupado      <= 1'b0;
         concluido    <= 1'b0;
         abortado     <= 1'b0;
      end else begin
         estado       <= estado_n;
         cmd_ativo    <= cmd_ativo_n;
         cnt          <= cnt_n;
         motor_frente <= atu_n[2];
         motor_giro   <= atu_n[1];
         garra        <= atu_n[0];
         ack_nav      <= ack_nav_n;
         ack_seg      <= ack_seg_n;
         ocupado      <= (estado_n != OCIOSO);
         concluido    <= concluido_n;
         abortado     <= abortado_n;
      end
   end

endmodule
